eight_to_four_tx: RTL and testbench

- Byte-to-nibble MII-style transmit serializer; the transmit-side counterpart of the nibble-to-byte receive path.
- Takes frame payload bytes from a show-ahead byte source (FIFO) and emits a 4-bit nibble stream with tx_en: 7 bytes of preamble 0x55, SFD 0xD5, the payload (low nibble first), zero padding up to a minimum length, then an inter-frame gap.
- Sits between the TX frame FIFO and the PHY/nibble link.

---
 rtl/eight_to_four_tx_pkg.sv | 30 +++
 rtl/eight_to_four_tx.sv | 115 +++++++++++
 tb/tb_eight_to_four_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/eight_to_four_tx_pkg.sv
// Shared constants for the byte-to-nibble transmit path and its receive-side checker.
package eight_to_four_tx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    SFD_LO,
    SFD_HI,
    DATA_LO,
    DATA_HI,
    PAD_LO,
    PAD_HI,
    IFG
  } tx_state_e;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_HI_NIB   = 4'hD;

  localparam int DEF_PREAMBLE_BYTES = 7;
  localparam int DEF_MIN_BYTES      = 60;
  localparam int DEF_IFG_NIBBLES    = 24;

  localparam int BYTE_CNT_W = 11;

  // Byte counter sticks at its maximum instead of wrapping on jumbo frames.
  function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/eight_to_four_tx.sv
// Byte-to-nibble transmit serializer: preamble, SFD, payload low nibble first,
// zero padding to a minimum length, then a fixed inter-frame gap.
module eight_to_four_tx
  import eight_to_four_tx_pkg::*;
#(
  parameter int PREAMBLE_BYTES = DEF_PREAMBLE_BYTES,
  parameter int MIN_BYTES      = DEF_MIN_BYTES,
  parameter int IFG_NIBBLES    = DEF_IFG_NIBBLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] datain,
  input  logic       ena,
  output logic       ren,
  output logic [3:0] dataout,
  output logic       tx_en,
  output logic       busy,
  output logic       error_empty
);

  // PRE covers all preamble nibbles but the last; SFD_LO supplies that one.
  localparam logic [4:0]            PRE_LAST = 5'(2*PREAMBLE_BYTES-1);
  localparam logic [4:0]            IFG_LAST = 5'(IFG_NIBBLES-1);
  localparam logic [BYTE_CNT_W-1:0] MIN_CNT  = BYTE_CNT_W'(MIN_BYTES);

  tx_state_e             state_q, state_d;
  logic [4:0]            nib_cnt_q, nib_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]            hold_q, hold_d;
  logic [3:0]            dataout_q, dataout_d;
  logic                  tx_en_q, tx_en_d;
  logic                  err_q, err_d;

  // The source advances only at byte boundaries that actually take a byte.
  assign ren         = ena & ((state_q == SFD_HI) | (state_q == DATA_HI));
  assign busy        = (state_q != IDLE);
  assign dataout     = dataout_q;
  assign tx_en       = tx_en_q;
  assign error_empty = err_q;

  // Next state plus the nibble that the next state puts on the wire.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    byte_cnt_d = byte_cnt_q;
    dataout_d  = 4'h0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        if (ena) begin
          state_d   = PRE;
          dataout_d = PREAMBLE_NIB;
        end
      end
      PRE: begin
        dataout_d = PREAMBLE_NIB;
        if (nib_cnt_q == PRE_LAST) state_d = SFD_LO;
      end
      SFD_LO: begin
        state_d   = SFD_HI;
        dataout_d = SFD_HI_NIB;
      end
      SFD_HI, DATA_HI: begin
        if (ena) begin
          hold_d     = datain;
          dataout_d  = datain[3:0];
          state_d    = DATA_LO;
          byte_cnt_d = sat_inc(byte_cnt_q);
        end else begin
          err_d   = (state_q == SFD_HI);
          state_d = (byte_cnt_q < MIN_CNT) ? PAD_LO : IFG;
        end
      end
      DATA_LO: begin
        state_d   = DATA_HI;
        dataout_d = hold_q[7:4];
      end
      PAD_LO: state_d = PAD_HI;
      PAD_HI: begin
        byte_cnt_d = sat_inc(byte_cnt_q);
        state_d    = (byte_cnt_d >= MIN_CNT) ? IFG : PAD_LO;
      end
      IFG: begin
        if (nib_cnt_q == IFG_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_en_d   = (state_d != IDLE) && (state_d != IFG);
    nib_cnt_d = ((state_d == state_q) && (state_q == PRE || state_q == IFG)) ?
                nib_cnt_q + 5'd1 : 5'd0;
  end

  // State and registered outputs; reset truncates any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      nib_cnt_q  <= '0;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      dataout_q  <= '0;
      tx_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_cnt_q  <= nib_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
      dataout_q  <= dataout_d;
      tx_en_q    <= tx_en_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_eight_to_four_tx.sv
// Randomized frame bench: a show-ahead byte queue feeds the serializer and each
// transmitted burst is compared against the nibble stream built from frame rules.
module tb_eight_to_four_tx;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [3:0] nib_q_t[$];

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] datain;
  logic       ena;
  logic       ren;
  logic [3:0] dataout;
  logic       tx_en;
  logic       busy;
  logic       error_empty;

  int n_chk = 0;
  int n_err = 0;

  byte_q_t src;
  bit      force_ena = 0;

  // monitor state
  bit     ren_s = 0;
  bit     prev_tx = 0;
  int     low_run = 0;
  int     last_gap = 0;
  nib_q_t burst;
  nib_q_t done_burst;
  bit     burst_done = 0;
  int     ren_cnt = 0;
  int     err_cnt = 0;
  int     viol = 0;

  eight_to_four_tx dut (
    .clock       (clock),
    .reset       (reset),
    .datain      (datain),
    .ena         (ena),
    .ren         (ren),
    .dataout     (dataout),
    .tx_en       (tx_en),
    .busy        (busy),
    .error_empty (error_empty)
  );

  always #5 clock = ~clock;

  // Sample everything mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    ren_s = ren;
    if (ren) ren_cnt++;
    if (error_empty) err_cnt++;
    if (!tx_en && dataout != 4'h0) viol++;
    if (tx_en && !busy) viol++;
    if (tx_en) begin
      if (!prev_tx) last_gap = low_run;
      burst.push_back(dataout);
      low_run = 0;
    end else begin
      if (prev_tx) begin
        done_burst = burst;
        burst      = {};
        burst_done = 1;
      end
      low_run++;
    end
    prev_tx = tx_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: the source pops if the edge took a byte, then inputs are redriven.
  task automatic tick();
    @(posedge clock);
    if (ren_s && src.size() > 0) void'(src.pop_front());
    #1;
    ena    = force_ena || (src.size() > 0);
    datain = (src.size() > 0) ? src[0] : 8'($urandom);
  endtask

  // Wire image of one frame built from the framing rules.
  function automatic nib_q_t model(input byte_q_t pl);
    nib_q_t q;
    int     nb;
    repeat (15) q.push_back(4'h5);
    q.push_back(4'hD);
    foreach (pl[i]) begin
      q.push_back(pl[i][3:0]);
      q.push_back(pl[i][7:4]);
    end
    nb = (pl.size() < 60) ? 60 : pl.size();
    repeat (2*(nb - pl.size())) q.push_back(4'h0);
    return q;
  endfunction

  function automatic byte_q_t rand_pl(input int n);
    byte_q_t q;
    repeat (n) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic finish_frame(input byte_q_t pl, input bit chk_gap, input string tag);
    nib_q_t exp;
    int     t = 0;
    int     e0;
    exp = model(pl);
    while (!burst_done && t < 3000) begin
      tick();
      t++;
    end
    chk({tag, "_timeout"}, {31'd0, burst_done}, 32'd1);
    if (!burst_done) return;
    burst_done = 0;
    chk({tag, "_len"}, done_burst.size(), exp.size());
    e0 = n_err;
    for (int i = 0; i < exp.size() && i < done_burst.size(); i++) begin
      chk($sformatf("%s_nib%0d", tag, i), {28'd0, done_burst[i]}, {28'd0, exp[i]});
      if (n_err != e0) break;
    end
    chk({tag, "_ren"}, ren_cnt, pl.size());
    chk({tag, "_err_empty"}, err_cnt, (pl.size() == 0) ? 1 : 0);
    if (chk_gap) chk({tag, "_gap"}, last_gap, 25);
  endtask

  task automatic run_frame(input byte_q_t pl, input bit chk_gap, input string tag);
    ren_cnt = 0;
    err_cnt = 0;
    foreach (pl[i]) src.push_back(pl[i]);
    finish_frame(pl, chk_gap, tag);
  endtask

  initial begin
    byte_q_t pl;
    int      t;
    reset  = 1'b1;
    ena    = 1'b0;
    datain = 8'h00;
    repeat (3) tick();
    chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("rst_dout", {28'd0, dataout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ren", {31'd0, ren}, 32'd0);
    chk("rst_err", {31'd0, error_empty}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_tx_en", {31'd0, tx_en}, 32'd0);

    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    run_frame(pl, 0, "ramp64");

    pl = '{8'hAA, 8'hBB, 8'hCC};
    run_frame(pl, 1, "short3");

    // empty frame: ena for a single edge while the source is already dry
    t = 0;
    while (busy && t < 200) begin
      tick();
      t++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
    ren_cnt   = 0;
    err_cnt   = 0;
    force_ena = 1;
    tick();
    force_ena = 0;
    tick();
    pl = {};
    finish_frame(pl, 0, "empty");

    run_frame(rand_pl(60), 1, "b2b_a");
    run_frame(rand_pl(60), 1, "b2b_b");
    run_frame(rand_pl(70), 1, "stall70");
    for (int k = 0; k < 4; k++)
      run_frame(rand_pl($urandom_range(1, 90)), 1, $sformatf("rnd%0d", k));

    // reset in the middle of the payload
    ren_cnt = 0;
    pl = rand_pl(64);
    foreach (pl[i]) src.push_back(pl[i]);
    t = 0;
    while (ren_cnt < 10 && t < 500) begin
      tick();
      t++;
    end
    chk("mid_bytes", ren_cnt, 10);
    reset = 1'b1;
    tick();
    chk("mid_rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("mid_rst_dout", {28'd0, dataout}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("restart_tx_en", {31'd0, tx_en}, 32'd1);
    chk("restart_dout", {28'd0, dataout}, 32'd5);
    pl         = src;
    burst_done = 0;
    ren_cnt    = 0;
    err_cnt    = 0;
    finish_frame(pl, 0, "after_rst");

    repeat (30) tick();
    chk("idle_dout_busy", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
